reset_sequencer: RTL and testbench

- Chip-level reset controller that sequences reset release for the peripheral and CPU domains.
- Merges three reset sources: power-on/pin reset (rst_async_n), software reset request and watchdog reset request.
- Synchronizes the asynchronous reset internally and releases rst_periph_n before rst_cpu_n, with programmable gaps between them.
- Records the cause of the last reset for firmware to read.

---
 rtl/reset_sequencer_if.sv | 33 +++
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the reset sequencer's control inputs and reset/status outputs.
//   sw_rst_req   : software reset request (level, synchronous to clk)
//   wdt_rst_req  : watchdog reset request (level, synchronous to clk)
//   cpu_hold     : debug hold keeping the CPU in reset after peripherals
//   cause_clr    : clears the sticky reset cause while running
//   rst_periph_n : peripheral-domain reset, active low
//   rst_cpu_n    : CPU-domain reset, active low
//   rst_cause    : sticky cause {WDT, SW, POR}
//   seq_busy     : high while the sequencer is not in RUN
// master = the side issuing requests (SoC / bench); slave = the sequencer.
// -----------------------------------------------------------------------------
interface reset_sequencer_if;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       cpu_hold;
  logic       cause_clr;
  logic       rst_periph_n;
  logic       rst_cpu_n;
  logic [2:0] rst_cause;
  logic       seq_busy;

  modport master (
    output sw_rst_req, wdt_rst_req, cpu_hold, cause_clr,
    input  rst_periph_n, rst_cpu_n, rst_cause, seq_busy
  );

  modport slave (
    input  sw_rst_req, wdt_rst_req, cpu_hold, cause_clr,
    output rst_periph_n, rst_cpu_n, rst_cause, seq_busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Chip-level reset controller. Merges pin/POR, software and watchdog resets,
// releases the peripheral domain first and the CPU domain CPU_DLY cycles
// later, and records the cause of the last reset.
// Ports:
//   clk         : system clock, rising edge
//   rst_async_n : asynchronous active-low pin/POR reset
//   bus         : reset_sequencer_if.slave (requests in, resets/status out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int ASSERT_CYCLES = 16,
  parameter int CPU_DLY       = 8,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_async_n,
  reset_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DLY - 1);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_CPU = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  logic             sync_m_q;
  logic             sync_r_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rst_periph_n_q;
  logic             rst_cpu_n_q;
  logic [2:0]       rst_cause_q;
  logic             seq_busy_q;

  // Reset synchronizer: assertion is asynchronous, release is delayed by two
  // edges so the ASSERT counter only starts on a clean, synchronous signal.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would collapse the two
  // stages into one.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sync_m_q <= 1'b0;
      sync_r_q <= 1'b0;
    end else begin
      sync_m_q <= 1'b1;
      sync_r_q <= sync_m_q;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q        <= ST_ASSERT;
      cnt_q          <= '0;
      rst_periph_n_q <= 1'b0;
      rst_cpu_n_q    <= 1'b0;
      rst_cause_q    <= 3'b001;
      seq_busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          // Counting is frozen until the synchronizer has released.
          if (sync_r_q) begin
            if (cnt_q == ASSERT_LAST) begin
              state_q        <= ST_WAIT_CPU;
              cnt_q          <= '0;
              rst_periph_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_WAIT_CPU: begin
          // cnt saturates so a long cpu_hold releases on the first edge
          // after the hold drops.
          if (cnt_q == CPU_LAST) begin
            if (!bus.cpu_hold) begin
              state_q     <= ST_RUN;
              rst_cpu_n_q <= 1'b1;
              seq_busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          // A new request outranks cause_clr on the same edge.
          if (bus.sw_rst_req || bus.wdt_rst_req) begin
            state_q        <= ST_ASSERT;
            cnt_q          <= '0;
            rst_periph_n_q <= 1'b0;
            rst_cpu_n_q    <= 1'b0;
            seq_busy_q     <= 1'b1;
            rst_cause_q    <= {bus.wdt_rst_req, bus.sw_rst_req, 1'b0};
          end else if (bus.cause_clr) begin
            rst_cause_q <= 3'b000;
          end
        end

        default: begin
          state_q        <= ST_ASSERT;
          cnt_q          <= '0;
          rst_periph_n_q <= 1'b0;
          rst_cpu_n_q    <= 1'b0;
          seq_busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rst_periph_n = rst_periph_n_q;
  assign bus.rst_cpu_n    = rst_cpu_n_q;
  assign bus.rst_cause    = rst_cause_q;
  assign bus.seq_busy     = seq_busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. Edges are
// numbered from the first posedge after the most recent rst_async_n release;
// outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic clk;
  logic rst_async_n;
  int   vectors;
  int   miscompares;
  int   edge_n;

  reset_sequencer_if bus ();

  reset_sequencer #(
    .ASSERT_CYCLES (16),
    .CPU_DLY       (8),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Invariant: the CPU is never out of reset while peripherals are in reset.
  always @(negedge clk) begin
    if (rst_async_n === 1'b1) begin
      vectors++;
      assert (!(bus.rst_cpu_n === 1'b1 && bus.rst_periph_n !== 1'b1)) else begin
        miscompares++;
        $error("FAIL invariant: cpu_n=%b periph_n=%b", bus.rst_cpu_n, bus.rst_periph_n);
      end
    end
  end

  task automatic go_to(input int target);
    repeat (target - edge_n) @(posedge clk);
    edge_n = target;
    #1;
  endtask

  task automatic release_por();
    @(negedge clk);
    rst_async_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic check_outs(input string tag, input logic p, input logic c,
                            input logic b, input logic [2:0] cause);
    check({tag, ".periph"}, {2'b00, bus.rst_periph_n}, {2'b00, p});
    check({tag, ".cpu"},    {2'b00, bus.rst_cpu_n},    {2'b00, c});
    check({tag, ".busy"},   {2'b00, bus.seq_busy},     {2'b00, b});
    check({tag, ".cause"},  bus.rst_cause,             cause);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    edge_n          = 0;
    rst_async_n     = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    bus.cpu_hold    = 1'b0;
    bus.cause_clr   = 1'b0;

    // Held in reset with the clock running.
    repeat (3) @(posedge clk);
    #1;
    check_outs("por_hold", 1'b0, 1'b0, 1'b1, 3'b001);

    // POR release: periph after edge 18, CPU after edge 26.
    release_por();
    go_to(17); check_outs("por_e17", 1'b0, 1'b0, 1'b1, 3'b001);
    go_to(18); check_outs("por_e18", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(25); check_outs("por_e25", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(26); check_outs("por_e26", 1'b1, 1'b1, 1'b0, 3'b001);

    // One-cycle SW request sampled at edge 100.
    go_to(99);
    bus.sw_rst_req = 1'b1;
    go_to(100); check_outs("sw_e100", 1'b0, 1'b0, 1'b1, 3'b010);
    bus.sw_rst_req = 1'b0;
    go_to(115); check_outs("sw_e115", 1'b0, 1'b0, 1'b1, 3'b010);
    go_to(116); check_outs("sw_e116", 1'b1, 1'b0, 1'b1, 3'b010);
    go_to(123); check_outs("sw_e123", 1'b1, 1'b0, 1'b1, 3'b010);
    go_to(124); check_outs("sw_e124", 1'b1, 1'b1, 1'b0, 3'b010);

    // SW and WDT on the same edge, together with cause_clr (request wins).
    go_to(129);
    bus.sw_rst_req  = 1'b1;
    bus.wdt_rst_req = 1'b1;
    bus.cause_clr   = 1'b1;
    go_to(130); check_outs("both_e130", 1'b0, 1'b0, 1'b1, 3'b110);
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    bus.cause_clr   = 1'b0;
    go_to(145); check_outs("both_e145", 1'b0, 1'b0, 1'b1, 3'b110);
    go_to(146); check_outs("both_e146", 1'b1, 1'b0, 1'b1, 3'b110);
    go_to(153); check_outs("both_e153", 1'b1, 1'b0, 1'b1, 3'b110);
    go_to(154); check_outs("both_e154", 1'b1, 1'b1, 1'b0, 3'b110);

    // cause_clr in RUN clears the cause.
    go_to(159);
    bus.cause_clr = 1'b1;
    go_to(160); check_outs("clr_e160", 1'b1, 1'b1, 1'b0, 3'b000);
    bus.cause_clr = 1'b0;

    // WDT-only request, then SW + cause_clr pulsed during WAIT_CPU (ignored).
    go_to(199);
    bus.wdt_rst_req = 1'b1;
    go_to(200); check_outs("wdt_e200", 1'b0, 1'b0, 1'b1, 3'b100);
    bus.wdt_rst_req = 1'b0;
    go_to(216); check_outs("wdt_e216", 1'b1, 1'b0, 1'b1, 3'b100);
    go_to(218);
    bus.sw_rst_req = 1'b1;
    bus.cause_clr  = 1'b1;
    go_to(219); check_outs("ign_e219", 1'b1, 1'b0, 1'b1, 3'b100);
    bus.sw_rst_req = 1'b0;
    bus.cause_clr  = 1'b0;
    go_to(223); check_outs("ign_e223", 1'b1, 1'b0, 1'b1, 3'b100);
    go_to(224); check_outs("ign_e224", 1'b1, 1'b1, 1'b0, 3'b100);

    // Request held high: retriggers once per RUN entry, and immediately
    // on the edge RUN is re-entered.
    go_to(249);
    bus.sw_rst_req = 1'b1;
    go_to(250); check_outs("hold_e250", 1'b0, 1'b0, 1'b1, 3'b010);
    go_to(274); check_outs("hold_e274", 1'b1, 1'b1, 1'b0, 3'b010);
    go_to(275); check_outs("hold_e275", 1'b0, 1'b0, 1'b1, 3'b010);
    bus.sw_rst_req = 1'b0;
    go_to(299); check_outs("hold_e299", 1'b1, 1'b1, 1'b0, 3'b010);

    // SW reset at edge 300, then rst_async_n pulsed at edge 310.
    bus.sw_rst_req = 1'b1;
    go_to(300); check_outs("abort_e300", 1'b0, 1'b0, 1'b1, 3'b010);
    bus.sw_rst_req = 1'b0;
    go_to(310);
    #1 rst_async_n = 1'b0;
    #1 check_outs("abort_async", 1'b0, 1'b0, 1'b1, 3'b001);

    // Fresh POR with cpu_hold asserted: CPU held until cpu_hold drops.
    bus.cpu_hold = 1'b1;
    release_por();
    go_to(17); check_outs("hold_por_e17", 1'b0, 1'b0, 1'b1, 3'b001);
    go_to(18); check_outs("hold_por_e18", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(26); check_outs("hold_por_e26", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(69); check_outs("hold_por_e69", 1'b1, 1'b0, 1'b1, 3'b001);
    bus.cpu_hold = 1'b0;
    go_to(70); check_outs("hold_por_e70", 1'b1, 1'b1, 1'b0, 3'b001);

    // Async reset from RUN, then plain POR timing repeats.
    go_to(80);
    #1 rst_async_n = 1'b0;
    #1 check_outs("run_async", 1'b0, 1'b0, 1'b1, 3'b001);
    release_por();
    go_to(17); check_outs("por2_e17", 1'b0, 1'b0, 1'b1, 3'b001);
    go_to(18); check_outs("por2_e18", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(25); check_outs("por2_e25", 1'b1, 1'b0, 1'b1, 3'b001);
    go_to(26); check_outs("por2_e26", 1'b1, 1'b1, 1'b0, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
